// File: rtl/sfx_sequencer.sv
// Purpose : sound-effect sequencer; plays a fixed note melody per game event to the square-wave synth.
// Latency : event sampled at posedge k -> note 0 on HALF_PERIOD/ENABLE/BUSY after posedge k+1.
// Backpr. : none; higher/equal-priority events restart playback, lower-priority events are dropped.
//
// Ports:
//   CLK, RESET_N               clock, asynchronous active-low reset
//   EV_PADDLE/EV_BRICK/EV_LOSE game events, rising edge starts effect 0/1/2
//   HALF_PERIOD[15:0]          half period of the current note (holds after the effect)
//   ENABLE                     high while a note sounds
//   BUSY                       high from effect start until its last note ends
// Parameter TICK_DIV: clock cycles per duration tick (>= 2).
// Optional macro SFX_GAP_EN: one silent tick between consecutive notes of an effect.
module sfx_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EV_PADDLE,
  input  logic        EV_BRICK,
  input  logic        EV_LOSE,
  output logic [15:0] HALF_PERIOD,
  output logic        ENABLE,
  output logic        BUSY
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef SFX_GAP_EN
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  // Note ROM: {half period, duration in ticks}
  function automatic logic [23:0] note_rom(input logic [1:0] e, input logic [1:0] i);
    case ({e, i})
      4'b00_00: note_rom = {16'd440, 8'd30};
      4'b01_00: note_rom = {16'd220, 8'd20};
      4'b01_01: note_rom = {16'd165, 8'd20};
      4'b10_00: note_rom = {16'd330, 8'd100};
      4'b10_01: note_rom = {16'd440, 8'd100};
      4'b10_10: note_rom = {16'd660, 8'd100};
      4'b10_11: note_rom = {16'd880, 8'd200};
      default:  note_rom = 24'd0;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] e);
    case (e)
      2'd1:    last_idx = 2'd1;
      2'd2:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  state_t          state, state_nx;
  logic [2:0]      ev_d, edge_q;
  logic [1:0]      eff_q, idx_q;
  logic [PW-1:0]   presc;
  logic [7:0]      dur_cnt;
  logic            tick, note_end, accept, edge_any;
  logic [1:0]      edge_eff;
  logic            load;
  logic [1:0]      ld_eff, ld_idx;
  logic [23:0]     cur_note, ld_note;
  logic            enable_nx, busy_nx;

  // Edge detect; the pulse is registered so the FSM never sees inputs combinationally.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ev_d   <= 3'b000;
      edge_q <= 3'b000;
    end else begin
      ev_d   <= {EV_LOSE, EV_BRICK, EV_PADDLE};
      edge_q <= {EV_LOSE, EV_BRICK, EV_PADDLE} & ~ev_d;
    end
  end

  always_comb begin
    edge_any = |edge_q;
    if (edge_q[2])      edge_eff = 2'd2;
    else if (edge_q[1]) edge_eff = 2'd1;
    else                edge_eff = 2'd0;
    // Equal priority also restarts, so a repeat event replays from note 0.
    accept   = edge_any && ((state == IDLE) || (edge_eff >= eff_q));
    cur_note = note_rom(eff_q, idx_q);
    tick     = (presc == PW'(TICK_DIV - 1));
    note_end = tick && (dur_cnt == cur_note[7:0] - 8'd1);
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM: next state and note-load decisions
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ld_eff   = eff_q;
    ld_idx   = idx_q;
    if (accept) begin
      state_nx = PLAY;
      load     = 1'b1;
      ld_eff   = edge_eff;
      ld_idx   = 2'd0;
    end else begin
      case (state)
        PLAY: begin
          if (note_end) begin
            if (idx_q == last_idx(eff_q)) begin
              state_nx = IDLE;
            end else begin
`ifdef SFX_GAP_EN
              state_nx = GAP;
`else
              load     = 1'b1;
              ld_idx   = idx_q + 2'd1;
`endif
            end
          end
        end
`ifdef SFX_GAP_EN
        GAP: begin
          if (tick) begin
            state_nx = PLAY;
            load     = 1'b1;
            ld_idx   = idx_q + 2'd1;
          end
        end
`endif
        default: state_nx = state;
      endcase
    end
    ld_note = note_rom(ld_eff, ld_idx);
  end

  // FSM: output decode (registered below so outputs come straight from flops)
  always_comb begin
    enable_nx = (state_nx == PLAY);
    busy_nx   = (state_nx != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      eff_q       <= 2'd0;
      idx_q       <= 2'd0;
      presc       <= '0;
      dur_cnt     <= 8'd0;
      HALF_PERIOD <= 16'd0;
      ENABLE      <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      ENABLE <= enable_nx;
      BUSY   <= busy_nx;
      if (load) begin
        eff_q       <= ld_eff;
        idx_q       <= ld_idx;
        HALF_PERIOD <= ld_note[23:8];
      end
      // Prescaler and duration restart on every note load and state change,
      // so each note (and the gap) is timed from its own first cycle.
      if (load || (state_nx != state) || (state_nx == IDLE)) begin
        presc   <= '0;
        dur_cnt <= 8'd0;
      end else if (tick) begin
        presc   <= '0;
        dur_cnt <= dur_cnt + 8'd1;
      end else begin
        presc   <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Purpose : randomized + directed bench for sfx_sequencer against a cycle-count reference model.
// Latency : model applies an event two posedges after the input is first driven high.
// Backpr. : n/a.
module tb_sfx_sequencer;

  localparam int TD = 4;
`ifdef SFX_GAP_EN
  localparam int GAPC = TD;
`else
  localparam int GAPC = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        EV_PADDLE = 1'b0;
  logic        EV_BRICK = 1'b0;
  logic        EV_LOSE = 1'b0;
  logic [15:0] HALF_PERIOD;
  logic        ENABLE;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  sfx_sequencer #(.TICK_DIV(TD)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .EV_PADDLE  (EV_PADDLE),
    .EV_BRICK   (EV_BRICK),
    .EV_LOSE    (EV_LOSE),
    .HALF_PERIOD(HALF_PERIOD),
    .ENABLE     (ENABLE),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Melody table straight from the effect list
  int hp_tbl  [3][4] = '{'{440, 0, 0, 0}, '{220, 165, 0, 0}, '{330, 440, 660, 880}};
  int dur_tbl [3][4] = '{'{30, 0, 0, 0},  '{20, 20, 0, 0},   '{100, 100, 100, 200}};
  int n_notes [3]    = '{1, 2, 4};

  // Model: remaining cycles of the note / gap, not ticks
  int         m_hp = 0, m_en = 0, m_busy = 0, m_eff = 0, m_idx = 0, m_rem = 0, m_gap = 0;
  logic [2:0] m_prev = 3'b000, m_pend = 3'b000;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hp = 0; m_en = 0; m_busy = 0; m_eff = 0; m_idx = 0; m_rem = 0; m_gap = 0;
    m_prev = 3'b000; m_pend = 3'b000;
  endtask

  task automatic load_note(input int e, input int i);
    m_eff = e; m_idx = i; m_hp = hp_tbl[e][i];
    m_en = 1; m_busy = 1; m_rem = dur_tbl[e][i] * TD; m_gap = 0;
  endtask

  task automatic model_step();
    logic [2:0] ev;
    int p;
    ev = {EV_LOSE, EV_BRICK, EV_PADDLE};
    p  = m_pend[2] ? 2 : m_pend[1] ? 1 : m_pend[0] ? 0 : -1;
    if (p >= 0 && (m_busy == 0 || p >= m_eff)) begin
      load_note(p, 0);
    end else if (m_busy != 0) begin
      if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) load_note(m_eff, m_idx + 1);
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_idx == n_notes[m_eff] - 1) begin
            m_en = 0; m_busy = 0;
          end else if (GAPC > 0) begin
            m_en = 0; m_gap = GAPC;
          end else begin
            load_note(m_eff, m_idx + 1);
          end
        end
      end
    end
    m_pend = ev & ~m_prev;
    m_prev = ev;
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RESET_N) model_step();
    else         model_reset();
    @(negedge CLK);
    chk("hp",   int'(HALF_PERIOD), m_hp);
    chk("en",   int'(ENABLE),      m_en);
    chk("busy", int'(BUSY),        m_busy);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input logic [2:0] mask);
    {EV_LOSE, EV_BRICK, EV_PADDLE} = mask;
    cycle();
    {EV_LOSE, EV_BRICK, EV_PADDLE} = 3'b000;
  endtask

  // Counts BUSY cycles until the effect ends; optional one-cycle injected event.
  task automatic measure(input int inj_at, input logic [2:0] inj_mask, input int budget,
                         output int busy_n);
    bit seen;
    seen   = 1'b0;
    busy_n = 0;
    for (int i = 0; i < budget; i++) begin
      {EV_LOSE, EV_BRICK, EV_PADDLE} = (i == inj_at) ? inj_mask : 3'b000;
      cycle();
      if (BUSY) begin
        busy_n++;
        seen = 1'b1;
      end else if (seen) begin
        return;
      end
    end
    chk("measure_timeout", 0, 1);
  endtask

  initial begin
    int bn;
    int cnt;

    // Reset state
    run(3);
    chk("rst_hp", int'(HALF_PERIOD), 0);
    chk("rst_en", int'(ENABLE), 0);
    chk("rst_busy", int'(BUSY), 0);
    RESET_N = 1'b1;
    run(5);

    // 1: single paddle note
    pulse(3'b001);
    measure(-1, 3'b000, 400, bn);
    chk("t1_len", bn, 30 * TD);
    run(2);
    chk("t1_hold_hp", int'(HALF_PERIOD), 440);

    // 2: brick two notes
    pulse(3'b010);
    measure(-1, 3'b000, 400, bn);
    chk("t2_len", bn, 40 * TD + GAPC);
    run(3);

    // 3: lose with a lower-priority paddle during note 2
    pulse(3'b100);
    measure(850, 3'b001, 3000, bn);
    chk("t3_len", bn, 500 * TD + 3 * GAPC);
    run(3);

    // 4: paddle preempted by lose after 50 cycles
    pulse(3'b001);
    measure(50, 3'b100, 3000, bn);
    chk("t4_len", bn, 51 + 500 * TD + 3 * GAPC);
    run(3);

    // 5: simultaneous paddle+brick, then brick held high
    pulse(3'b011);
    measure(-1, 3'b000, 400, bn);
    chk("t5_len", bn, 40 * TD + GAPC);
    run(3);
    EV_BRICK = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (BUSY) cnt++;
    end
    chk("t5_hold_len", cnt, 40 * TD + GAPC);
    EV_BRICK = 1'b0;
    run(3);

    // 6: asynchronous reset during the 440 note of lose
    pulse(3'b100);
    run(600);
    chk("t6_pre_hp", int'(HALF_PERIOD), 440);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_async_hp", int'(HALF_PERIOD), 0);
    chk("t6_async_en", int'(ENABLE), 0);
    chk("t6_async_busy", int'(BUSY), 0);
    model_reset();
    run(3);
    RESET_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (BUSY) cnt++;
    end
    chk("t6_stay_idle", cnt, 0);

    // Input already high at reset release triggers
    EV_PADDLE = 1'b1;
    #2 RESET_N = 1'b0;
    run(2);
    RESET_N = 1'b1;
    run(30 * TD + 10);
    EV_PADDLE = 1'b0;
    run(3);

    // Random event traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(1, 7));
      {EV_LOSE, EV_BRICK, EV_PADDLE} = mask;
      run($urandom_range(1, 3));
      {EV_LOSE, EV_BRICK, EV_PADDLE} = 3'b000;
      run($urandom_range(1, 500));
    end
    measure(-1, 3'b000, 3000, bn);
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer that drives the square-wave synthesiser. On a game event (paddle hit, brick hit, ball lost) it plays a short fixed melody from an internal note table, presenting a 16-bit half period and an enable to the synthesiser for each note's duration. It sits between the game logic and the synthesiser. It owns effect priority, note timing and silence between effects.

## Interface
- `TICK_DIV`, default 50000: clock cycles per duration tick (1 ms at 50 MHz); minimum 2.
- `CLK` in 1: system clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `EV_PADDLE` in 1: paddle-hit event; rising edge starts effect 0.
- `EV_BRICK` in 1: brick-hit event; rising edge starts effect 1.
- `EV_LOSE` in 1: ball-lost event; rising edge starts effect 2.
- `HALF_PERIOD` out 16: half period of the current note, to the synthesiser.
- `ENABLE` out 1: high while a note sounds.
- `BUSY` out 1: high from effect start until its last note ends.

## Operation
- Note table (half period, duration in ticks), fixed ROM:
  - Effect 0 / PADDLE: (440, 30).
  - Effect 1 / BRICK: (220, 20), (165, 20).
  - Effect 2 / LOSE: (330, 100), (440, 100), (660, 100), (880, 200).
- Event inputs go through a one-flop delay for rising-edge detection. A level held high triggers once. Reset clears the delay flops to 0, so an input already high at reset release triggers.
- Priority:
  - LOSE beats BRICK beats PADDLE.
  - Simultaneous edges: only the highest is taken, the others are dropped.
  - While BUSY, an edge of equal or higher priority than the running effect restarts at note 0 of the new effect. A lower-priority edge is ignored.
- FSM states: IDLE, PLAY, GAP (GAP only with the macro).
  - IDLE: on an accepted edge, load note 0, clear the tick prescaler and duration counter, go to PLAY.
  - PLAY: ENABLE=1 and HALF_PERIOD=table value. When the duration counter reaches the note duration: on the last note go to IDLE; otherwise go to GAP (macro) or load the next note directly.
  - GAP: ENABLE=0, HALF_PERIOD holds. After one tick, load the next note and go to PLAY.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Emits a one-cycle tick on wrap.
  - Restarts from 0 at every effect start and every note load, so every note lasts exactly duration*TICK_DIV cycles.
- In IDLE: ENABLE=0 and BUSY=0; HALF_PERIOD holds the last note value.

## Timing
- Reset values:
  - Outputs: HALF_PERIOD=0, ENABLE=0, BUSY=0.
  - Internals: FSM in IDLE, counters at 0.
- Reset asserted mid-effect: outputs go to their reset values immediately (asynchronous). No effect resumes after release.
- Start latency: if the edge is sampled at posedge k, then HALF_PERIOD, ENABLE=1 and BUSY=1 are valid after posedge k+1.
- Note boundary, back-to-back: HALF_PERIOD changes in the cycle the old note would end. ENABLE stays high.
- End of effect: ENABLE and BUSY fall together, exactly duration*TICK_DIV cycles after the last note's first enabled cycle.
- Restart: on the cycle after the accepting edge, outputs show note 0 of the new effect. ENABLE has no low cycle.
- All outputs are registered; none is combinational from the inputs.

## Configuration
- `SFX_GAP_EN`
  - Defined: one tick of silence (ENABLE=0, BUSY=1) is inserted between consecutive notes of an effect. There is no gap after the last note.
  - Undefined: notes are back-to-back, and the GAP state and its logic are not built.

## Test plan
Bench runs with TICK_DIV=4.
1. Reset, then an EV_PADDLE pulse at posedge k: from after posedge k+1, HALF_PERIOD=440 and ENABLE=1 for exactly 120 cycles, then ENABLE=0 and BUSY=0, with HALF_PERIOD still 440.
2. EV_BRICK pulse, no macro: 80 cycles at 220, then 80 cycles at 165, with ENABLE continuously high. With `SFX_GAP_EN`: 80 at 220, 4 cycles with ENABLE=0 and BUSY=1, then 80 at 165.
3. EV_LOSE running; EV_PADDLE pulse during note 2 (660): playback is unaffected, and the total effect length is 2000 cycles without the macro.
4. EV_PADDLE running; EV_LOSE pulse after 50 cycles: on the next cycle HALF_PERIOD=330 and ENABLE stays 1, and the LOSE effect plays in full.
5. EV_PADDLE and EV_BRICK rise in the same cycle: only BRICK plays (220 then 165). EV_BRICK then held high for 1000 cycles: no retrigger after the first edge.
6. RESET_N asserted during the LOSE note at 440: HALF_PERIOD=0, ENABLE=0 and BUSY=0 immediately, before the next clock edge. After release, outputs stay idle until a new edge.
